// File: rtl/corr_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : corr_window_ctrl
// Purpose  : Window sequencer for the rectangular-window correlation counter:
//            sample strobe, per-window zeroing and result capture/handshake.
// Revision : 1.0 - initial release
// ============================================================================
module corr_window_ctrl #(
   parameter int TIME_W     = 8,
   parameter int PRESCALE_W = 16,
   parameter int DROP_W     = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic [PRESCALE_W-1:0] i_samplePeriod,
   input  logic [TIME_W-1:0]     i_windowLength,
   output logic                  o_cg,
   output logic                  o_zeroCounts,
   input  logic [TIME_W-1:0]     i_countX,
   input  logic [TIME_W-1:0]     i_countY,
   input  logic [TIME_W-1:0]     i_countIsect,
   input  logic [TIME_W-1:0]     i_countSymdiff,
   output logic [TIME_W-1:0]     o_resultX,
   output logic [TIME_W-1:0]     o_resultY,
   output logic [TIME_W-1:0]     o_resultIsect,
   output logic [TIME_W-1:0]     o_resultSymdiff,
   output logic                  o_resultValid,
   input  logic                  i_resultReady,
   output logic [DROP_W-1:0]     o_dropCount,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_END  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [PRESCALE_W-1:0]   r_pc;
   logic [TIME_W-1:0]       r_ws;
   logic [PRESCALE_W-1:0]   r_period;
   logic [TIME_W-1:0]       r_length;
   logic [TIME_W-1:0]       r_res_x;
   logic [TIME_W-1:0]       r_res_y;
   logic [TIME_W-1:0]       r_res_isect;
   logic [TIME_W-1:0]       r_res_symdiff;
   logic                    r_valid;
   logic [DROP_W-1:0]       r_drop;

   logic                    w_strobe;
   logic                    w_last;
   logic                    w_start_ok;
   logic                    w_fire;
   logic                    w_capture;
   logic                    w_drop;

   assign w_start_ok = i_enable && (i_windowLength != '0);
   assign w_strobe   = (r_state == S_RUN) && (r_pc == r_period);
   assign w_last     = w_strobe && (r_ws == (r_length - TIME_W'(1)));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Outputs are decoded from state and shadow registers only.
   always_comb begin
      w_next_state = r_state;
      o_cg         = 1'b0;
      o_zeroCounts = 1'b1;
      o_busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next_state = S_RUN;
         end
         S_RUN: begin
            o_cg         = w_strobe;
            o_zeroCounts = 1'b0;
            if (!i_enable)   w_next_state = S_IDLE;
            else if (w_last) w_next_state = S_END;
         end
         S_END: begin
            w_next_state = w_start_ok ? S_RUN : S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc     <= '0;
         r_ws     <= '0;
         r_period <= '0;
         r_length <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_END: begin
               if (r_state == S_END || w_start_ok) begin
                  r_period <= i_samplePeriod;
                  r_length <= i_windowLength;
               end
               r_pc <= '0;
               r_ws <= '0;
            end
            S_RUN: begin
               if (w_strobe) begin
                  r_pc <= '0;
                  r_ws <= w_last ? '0 : r_ws + TIME_W'(1);
               end else begin
                  r_pc <= r_pc + PRESCALE_W'(1);
               end
            end
            default: begin
               r_pc <= '0;
               r_ws <= '0;
            end
         endcase
      end
   end

   // A handshake in the END cycle frees the registers for the new window.
   assign w_fire    = r_valid && i_resultReady;
   assign w_capture = (r_state == S_END) && (!r_valid || w_fire);
   assign w_drop    = (r_state == S_END) && r_valid && !i_resultReady;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_res_x       <= '0;
         r_res_y       <= '0;
         r_res_isect   <= '0;
         r_res_symdiff <= '0;
         r_valid       <= 1'b0;
         r_drop        <= '0;
      end else begin
         if (w_capture) begin
            r_res_x       <= i_countX;
            r_res_y       <= i_countY;
            r_res_isect   <= i_countIsect;
            r_res_symdiff <= i_countSymdiff;
            r_valid       <= 1'b1;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
      end
   end

   assign o_resultX       = r_res_x;
   assign o_resultY       = r_res_y;
   assign o_resultIsect   = r_res_isect;
   assign o_resultSymdiff = r_res_symdiff;
   assign o_resultValid   = r_valid;
   assign o_dropCount     = r_drop;

endmodule
`default_nettype wire
